// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: per-register control codes,
// PC enable, redirect pending across memory wait states, perf counters and timeout.
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic [1:0]       ifid_ctl,
  output logic [1:0]       idex_ctl,
  output logic [1:0]       exmem_ctl,
  output logic [1:0]       memwb_ctl,
  output logic             redirect_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  typedef enum logic [1:0] {RUN, WAIT, RESUME} state_e;

  localparam logic [1:0] CTL_PASS  = 2'b00;
  localparam logic [1:0] CTL_HOLD  = 2'b01;
  localparam logic [1:0] CTL_FLUSH = 2'b11;
  localparam int         BW        = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             pend_redir_q, pend_redir_d;
  logic [BW-1:0]    busy_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             err_timeout_q;
  logic             flush_inc;
  logic             load_use;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // NOTE: every output and next-state signal gets a default before any branch,
  // so no path through this block can leave a value unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    pend_redir_d = pend_redir_q;
    flush_inc    = 1'b0;
    pc_en        = 1'b1;
    redirect_sel = 1'b0;
    ifid_ctl     = CTL_PASS;
    idex_ctl     = CTL_PASS;
    exmem_ctl    = CTL_PASS;
    memwb_ctl    = CTL_PASS;

    if (rst) begin
      pc_en     = 1'b0;
      ifid_ctl  = CTL_FLUSH;
      idex_ctl  = CTL_FLUSH;
      exmem_ctl = CTL_FLUSH;
      memwb_ctl = CTL_FLUSH;
    end else if (mem_busy) begin
      // Freeze everything upstream of MEM; WB receives bubbles until memory completes.
      pc_en     = 1'b0;
      ifid_ctl  = CTL_HOLD;
      idex_ctl  = CTL_HOLD;
      exmem_ctl = CTL_HOLD;
      memwb_ctl = CTL_FLUSH;
      state_d   = WAIT;
      if (state_q == RUN && ex_redirect) pend_redir_d = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_redirect) begin
            ifid_ctl  = CTL_FLUSH;
            idex_ctl  = CTL_FLUSH;
            flush_inc = 1'b1;
          end else if (load_use) begin
            pc_en    = 1'b0;
            ifid_ctl = CTL_HOLD;
            idex_ctl = CTL_FLUSH;
          end
        end
        WAIT: begin
          // EX was frozen, so any redirect from it is already in pend_redir_q.
          if (load_use) begin
            pc_en    = 1'b0;
            ifid_ctl = CTL_HOLD;
            idex_ctl = CTL_FLUSH;
          end
          state_d = pend_redir_q ? RESUME : RUN;
        end
        RESUME: begin
          redirect_sel = 1'b1;
          ifid_ctl     = CTL_FLUSH;
          idex_ctl     = CTL_FLUSH;
          pend_redir_d = 1'b0;
          flush_inc    = 1'b1;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pend_redir_q  <= 1'b0;
      busy_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_redir_q <= pend_redir_d;
      if (!mem_busy)               busy_cnt_q <= '0;
      else if (busy_cnt_q != '1)   busy_cnt_q <= busy_cnt_q + 1'b1;
      if (mem_busy && busy_cnt_q == BW'(TIMEOUT - 1)) err_timeout_q <= 1'b1;
      if (!pc_en && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign err_timeout = err_timeout_q;

endmodule
